// File: rtl/rpct_upd_ctrl.sv
// Return-PC-table update controller: sweeps the rpct sets clear at init, then
// queues exe-stage call/ret updates and issues them one per cycle. Optional flush: RPCT_UPD_FLUSH_EN.
module rpct_upd_ctrl #(
   parameter int SET_NUM = 8,
   parameter int QDEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       reinit,
   input  logic                       call_valid,
   input  logic [31:0]                call_pc,
   input  logic [31:0]                call_ret_pc,
   input  logic                       ret_valid,
   input  logic [31:0]                jrra_pc,
   input  logic [31:0]                ret_tgt_pc,
   input  logic                       flush,
   output logic                       upd_ready,
   output logic                       is_call,
   output logic                       is_ret,
   output logic [31:0]                call_pc_o,
   output logic [31:0]                ret_pc_o,
   output logic [31:0]                jrra_pc_o,
   output logic                       init_we,
   output logic [$clog2(SET_NUM)-1:0] init_idx,
   output logic                       init_done,
   output logic [7:0]                 drop_cnt
);
   localparam int IDX_W = $clog2(SET_NUM);
   localparam int PTR_W = $clog2(QDEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   init_idx_reg, init_idx_next;
   logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [OCC_W-1:0]   occ_reg, occ_next;
   logic [7:0]         drop_cnt_reg, drop_cnt_next;

   // Payload storage; type bit is 1 for a RET entry
   logic               type_mem [QDEPTH];
   logic [31:0]        a_mem    [QDEPTH];
   logic [31:0]        b_mem    [QDEPTH];

   logic               flush_act;
   logic               fifo_clear;
   logic               call_push, ret_push, call_drop, ret_drop;
   logic               head_valid, head_type;
   logic [1:0]         n_push, n_drop;
   logic [8:0]         drop_sum;
   logic               wr0_en, wr1_en, wr0_type;
   logic [31:0]        wr0_a, wr0_b;
   logic [PTR_W-1:0]   wr1_ptr;

`ifdef RPCT_UPD_FLUSH_EN
   assign flush_act = flush;
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign flush_act    = 1'b0;
`endif

   assign upd_ready = (occ_reg <= OCC_W'(QDEPTH - 2));

   assign call_push = call_valid &&  upd_ready && !flush_act;
   assign ret_push  = ret_valid  &&  upd_ready && !flush_act;
   assign call_drop = call_valid && !upd_ready && !flush_act;
   assign ret_drop  = ret_valid  && !upd_ready && !flush_act;
   assign n_push    = {1'b0, call_push} + {1'b0, ret_push};
   assign n_drop    = {1'b0, call_drop} + {1'b0, ret_drop};

   assign head_valid = (state_reg == ST_RUN) && (occ_reg != '0) && !flush_act;
   assign head_type  = type_mem[rd_ptr_reg];

   assign is_call   = head_valid && !head_type;
   assign is_ret    = head_valid &&  head_type;
   assign call_pc_o = is_call    ? a_mem[rd_ptr_reg] : 32'd0;
   assign jrra_pc_o = is_ret     ? a_mem[rd_ptr_reg] : 32'd0;
   assign ret_pc_o  = head_valid ? b_mem[rd_ptr_reg] : 32'd0;

   assign init_we   = (state_reg == ST_INIT);
   assign init_done = (state_reg == ST_RUN);
   assign init_idx  = init_idx_reg;
   assign drop_cnt  = drop_cnt_reg;

   always_comb begin
      state_next    = state_reg;
      init_idx_next = init_idx_reg;
      fifo_clear    = 1'b0;
      case (state_reg)
         ST_INIT: begin
            if (reinit) begin
               init_idx_next = '0;
            end else if (init_idx_reg == IDX_W'(SET_NUM - 1)) begin
               state_next    = ST_RUN;
               init_idx_next = '0;
            end else begin
               init_idx_next = init_idx_reg + 1'b1;
            end
         end
         ST_RUN: begin
            if (reinit) begin
               state_next    = ST_INIT;
               init_idx_next = '0;
               fifo_clear    = 1'b1;
            end
         end
         default: begin
            state_next    = ST_INIT;
            init_idx_next = '0;
         end
      endcase
   end

   always_comb begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(n_push);
      rd_ptr_next = rd_ptr_reg + PTR_W'(head_valid);
      occ_next    = occ_reg + OCC_W'(n_push) - OCC_W'(head_valid);
      if (fifo_clear || flush_act) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         occ_next    = '0;
      end
      drop_sum      = {1'b0, drop_cnt_reg} + 9'(n_drop);
      drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= ST_INIT;
         init_idx_reg <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         occ_reg      <= '0;
         drop_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         init_idx_reg <= init_idx_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         occ_reg      <= occ_next;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   // Port 0 takes the CALL when present, otherwise the lone RET; port 1 only on a dual push
   assign wr0_en   = call_push || ret_push;
   assign wr1_en   = call_push && ret_push;
   assign wr0_type = !call_push;
   assign wr0_a    = call_push ? call_pc     : jrra_pc;
   assign wr0_b    = call_push ? call_ret_pc : ret_tgt_pc;
   assign wr1_ptr  = wr_ptr_reg + 1'b1;

   always_ff @(posedge clk) begin
      if (wr0_en) begin
         type_mem[wr_ptr_reg] <= wr0_type;
         a_mem[wr_ptr_reg]    <= wr0_a;
         b_mem[wr_ptr_reg]    <= wr0_b;
      end
      if (wr1_en) begin
         type_mem[wr1_ptr] <= 1'b1;
         a_mem[wr1_ptr]    <= jrra_pc;
         b_mem[wr1_ptr]    <= ret_tgt_pc;
      end
   end
endmodule
